sd_dat_tx: RTL

// - SD 4-bit data-line write transmitter; consumer of the XORed (raw ^ OTP) block at ram read port.
// - Reads 1024 nibbles (one 512-byte block), frames them on D[3:0] with start bit, per-line CRC16, end bit.
// - Then samples the card's CRC status token and busy on D0; reports one done pulse plus a status code.

---
 rtl/sd_dat_tx_if.sv | 22 ++
 rtl/sd_dat_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sd_dat_tx_if.sv
// Bus bundle between the SD data-line write transmitter, its block RAM read port and the D[3:0] pads.
// The slave modport is the transmitter; the master modport is the RAM/pad/card side.
interface sd_dat_tx_if;
    logic       istart;
    logic [9:0] oaddr;
    logic [3:0] irdata;
    logic [3:0] odata_sd;
    logic       odata_sd_en;
    logic [3:0] idata_sd;
    logic       obusy;
    logic       odone;
    logic [1:0] ostatus;

    modport master (
        output istart, irdata, idata_sd,
        input  oaddr, odata_sd, odata_sd_en, obusy, odone, ostatus
    );
    modport slave (
        input  istart, irdata, idata_sd,
        output oaddr, odata_sd, odata_sd_en, obusy, odone, ostatus
    );
endinterface

// File: rtl/sd_dat_tx.sv
// SD 4-bit write transmitter: frames one 1024-nibble block with start bit, per-line CRC16 and end bit,
// then decodes the card's CRC status token and waits out busy on D0.
module sd_dat_tx #(
    parameter int NWR_CYCLES    = 2,
    parameter int TOKEN_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT  = 1000000
) (
    input  logic       iclk,
    input  logic       irst_n,
    sd_dat_tx_if.slave bus
);
    localparam int CMAX_A = (BUSY_TIMEOUT > TOKEN_TIMEOUT) ? BUSY_TIMEOUT : TOKEN_TIMEOUT;
    localparam int CMAX   = (CMAX_A > 1024) ? CMAX_A : 1024;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [3:0] {
        IDLE, PRE, START, DATA, CRC, END, WAIT_TOK, TOK, BUSY, DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0][15:0] crc;
    logic [2:0]      tok;
    logic [1:0]      pend;
    logic            d0;
    logic            unused_d;

    assign d0       = bus.idata_sd[0];
    assign unused_d = ^bus.idata_sd[3:1];

    function automatic logic [15:0] crc_step(logic [15:0] c, logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            crc             <= '0;
            tok             <= '0;
            pend            <= '0;
            bus.oaddr       <= '0;
            bus.odata_sd    <= 4'hF;
            bus.odata_sd_en <= 1'b0;
            bus.obusy       <= 1'b0;
            bus.odone       <= 1'b0;
            bus.ostatus     <= 2'b00;
        end else begin
            bus.odone <= 1'b0;
            case (state)
                IDLE: if (bus.istart) begin
                    state           <= PRE;
                    cnt             <= '0;
                    crc             <= '0;
                    bus.oaddr       <= '0;
                    bus.odata_sd    <= 4'hF;
                    bus.odata_sd_en <= 1'b1;
                    bus.obusy       <= 1'b1;
                end
                // Address 0 is held through PRE so its read data lands during START.
                PRE: if (cnt == CW'(NWR_CYCLES - 1)) begin
                    state        <= START;
                    cnt          <= '0;
                    bus.odata_sd <= 4'h0;
                    bus.oaddr    <= bus.oaddr + 10'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                START: begin
                    state        <= DATA;
                    bus.odata_sd <= bus.irdata;
                    for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], bus.irdata[i]);
                    bus.oaddr    <= bus.oaddr + 10'd1;
                end
                DATA: if (cnt == CW'(1023)) begin
                    state <= CRC;
                    cnt   <= '0;
                    for (int i = 0; i < 4; i++) begin
                        bus.odata_sd[i] <= crc[i][15];
                        crc[i]          <= {crc[i][14:0], 1'b0};
                    end
                end else begin
                    cnt          <= cnt + CW'(1);
                    bus.odata_sd <= bus.irdata;
                    for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], bus.irdata[i]);
                    if (bus.oaddr != 10'h3FF) bus.oaddr <= bus.oaddr + 10'd1;
                end
                CRC: if (cnt == CW'(15)) begin
                    state        <= END;
                    bus.odata_sd <= 4'hF;
                end else begin
                    cnt <= cnt + CW'(1);
                    for (int i = 0; i < 4; i++) begin
                        bus.odata_sd[i] <= crc[i][15];
                        crc[i]          <= {crc[i][14:0], 1'b0};
                    end
                end
                END: begin
                    state           <= WAIT_TOK;
                    cnt             <= CW'(1);
                    bus.odata_sd_en <= 1'b0;
                end
                WAIT_TOK: if (!d0) begin
                    state <= TOK;
                    cnt   <= '0;
                end else if (cnt == CW'(TOKEN_TIMEOUT)) begin
                    state       <= DONE;
                    bus.odone   <= 1'b1;
                    bus.ostatus <= 2'b11;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // Three status bits MSB first, then the end bit on the fourth cycle.
                TOK: if (cnt == CW'(3)) begin
                    state <= BUSY;
                    cnt   <= '0;
                    if (!d0)                 pend <= 2'b10;
                    else if (tok == 3'b010)  pend <= 2'b00;
                    else if (tok == 3'b101)  pend <= 2'b01;
                    else                     pend <= 2'b10;
                end else begin
                    tok <= {tok[1:0], d0};
                    cnt <= cnt + CW'(1);
                end
                BUSY: if (d0) begin
                    state       <= DONE;
                    bus.odone   <= 1'b1;
                    bus.ostatus <= pend;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    state       <= DONE;
                    bus.odone   <= 1'b1;
                    bus.ostatus <= 2'b11;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    state     <= IDLE;
                    bus.obusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
